// File: rtl/idct_pre_revbuf.sv
// Frame reorder buffer ahead of an IDCT: captures one frame of D(k) and replays it
// with D(k) and the mirrored D(N-k) side by side, one beat per cycle.
module idct_pre_revbuf #(
    parameter int wData  = 24,
    parameter int maxPts = 2048
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sink_valid_i,
    input  logic             sink_sop_i,
    input  logic             sink_eop_i,
    output logic             sink_ready_o,
    input  logic [1:0]       sink_error_i,
    input  logic [wData-1:0] sink_real_i,
    input  logic [wData-1:0] sink_imag_i,
    input  logic [11:0]      fftpts_in_i,
    output logic             source_valid_o,
    output logic             source_sop_o,
    output logic             source_eop_o,
    input  logic             source_ready_i,
    output logic [1:0]       source_error_o,
    output logic [wData-1:0] source_real_o,
    output logic [wData-1:0] source_imag_o,
    output logic [wData-1:0] source_real_rev_o,
    output logic [wData-1:0] source_imag_rev_o,
    output logic [11:0]      fftpts_out_o,
    output logic             frame_drop_o
);

    localparam int          AW    = $clog2(maxPts);
    localparam logic [12:0] MAX_N = 13'(maxPts);

    typedef enum logic {S_LOAD, S_DRAIN} state_t;

    state_t             state_q;
    logic [11:0]        wr_idx_q;
    logic [11:0]        rd_idx_q;
    logic [11:0]        n_q;
    logic [1:0]         err_q;
    logic               frame_drop_q;
    logic               source_valid_q, source_sop_q, source_eop_q;
    logic [1:0]         source_error_q;
    logic [wData-1:0]   source_real_q, source_imag_q;
    logic [wData-1:0]   source_real_rev_q, source_imag_rev_q;
    logic [11:0]        fftpts_out_q;

    // Two identical copies give the forward and mirrored read ports.
    logic [2*wData-1:0] mem_a [maxPts];
    logic [2*wData-1:0] mem_b [maxPts];

    logic               beat_acc;
    logic               n_legal;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [AW-1:0]      rd_addr;
    logic [AW-1:0]      rev_addr;
    logic               last_xfer;
    logic               advance;

    always_comb begin
        beat_acc  = sink_valid_i && (state_q == S_LOAD);
        n_legal   = (fftpts_in_i >= 12'd8) && ({1'b0, fftpts_in_i} <= MAX_N) &&
                    ((fftpts_in_i & (fftpts_in_i - 12'd1)) == 12'd0);
        wr_en     = beat_acc && (sink_sop_i ? n_legal : (wr_idx_q != 12'd0));
        wr_addr   = sink_sop_i ? '0 : AW'(wr_idx_q);
        rd_addr   = AW'(rd_idx_q);
        rev_addr  = AW'(n_q - rd_idx_q);
        last_xfer = (state_q == S_DRAIN) && source_valid_q && source_ready_i && source_eop_q;
        advance   = (state_q == S_DRAIN) && !last_xfer && (!source_valid_q || source_ready_i);
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_a[wr_addr] <= {sink_imag_i, sink_real_i};
            mem_b[wr_addr] <= {sink_imag_i, sink_real_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q           <= S_LOAD;
            wr_idx_q          <= '0;
            rd_idx_q          <= '0;
            n_q               <= '0;
            err_q             <= '0;
            frame_drop_q      <= 1'b0;
            source_valid_q    <= 1'b0;
            source_sop_q      <= 1'b0;
            source_eop_q      <= 1'b0;
            source_error_q    <= '0;
            source_real_q     <= '0;
            source_imag_q     <= '0;
            source_real_rev_q <= '0;
            source_imag_rev_q <= '0;
            fftpts_out_q      <= '0;
        end else begin
            frame_drop_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (beat_acc) begin
                        if (sink_sop_i) begin
                            if (n_legal && !sink_eop_i) begin
                                n_q      <= fftpts_in_i;
                                err_q    <= sink_error_i;
                                wr_idx_q <= 12'd1;
                            end else begin
                                frame_drop_q <= 1'b1;
                                wr_idx_q     <= '0;
                            end
                        end else if (wr_idx_q != 12'd0) begin
                            // Index 0 means no frame is open; stray beats fall through.
                            err_q <= err_q | sink_error_i;
                            if (wr_idx_q == n_q - 12'd1) begin
                                wr_idx_q <= '0;
                                if (sink_eop_i) begin
                                    state_q  <= S_DRAIN;
                                    rd_idx_q <= '0;
                                end else begin
                                    frame_drop_q <= 1'b1;
                                end
                            end else if (sink_eop_i) begin
                                frame_drop_q <= 1'b1;
                                wr_idx_q     <= '0;
                            end else begin
                                wr_idx_q <= wr_idx_q + 12'd1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_xfer) begin
                        source_valid_q <= 1'b0;
                        source_sop_q   <= 1'b0;
                        source_eop_q   <= 1'b0;
                        state_q        <= S_LOAD;
                    end else if (advance) begin
                        source_valid_q <= 1'b1;
                        source_sop_q   <= (rd_idx_q == 12'd0);
                        source_eop_q   <= (rd_idx_q == n_q - 12'd1);
                        source_error_q <= err_q;
                        fftpts_out_q   <= n_q;
                        source_real_q  <= mem_a[rd_addr][wData-1:0];
                        source_imag_q  <= mem_a[rd_addr][2*wData-1:wData];
                        if (rd_idx_q == 12'd0) begin
                            source_real_rev_q <= '0;
                            source_imag_rev_q <= '0;
                        end else begin
                            source_real_rev_q <= mem_b[rev_addr][wData-1:0];
                            source_imag_rev_q <= mem_b[rev_addr][2*wData-1:wData];
                        end
                        rd_idx_q <= rd_idx_q + 12'd1;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign sink_ready_o      = (state_q == S_LOAD);
    assign source_valid_o    = source_valid_q;
    assign source_sop_o      = source_sop_q;
    assign source_eop_o      = source_eop_q;
    assign source_error_o    = source_error_q;
    assign source_real_o     = source_real_q;
    assign source_imag_o     = source_imag_q;
    assign source_real_rev_o = source_real_rev_q;
    assign source_imag_rev_o = source_imag_rev_q;
    assign fftpts_out_o      = fftpts_out_q;
    assign frame_drop_o      = frame_drop_q;

endmodule
